// File: rtl/timekeeper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timekeeper_pkg                                         |
// | Description : Shared types, field limits, request indices and wrap   |
// |               helpers for the VGA clock timekeeping controller.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package timekeeper_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        DONE     = 2'd3
    } alarm_state_t;

    localparam logic [5:0] SEC_MAX    = 6'd59;
    localparam logic [5:0] MIN_MAX    = 6'd59;
    localparam logic [3:0] HRS_MAX    = 4'd11;
    localparam logic [5:0] AL_STEP    = 6'd10;
    // Last reachable alarm-minute value; the next step carries into hours.
    localparam logic [5:0] AL_MIN_MAX = 6'd50;

    // Pending-request bit positions; a lower index wins arbitration.
    localparam int PEND_W    = 5;
    localparam int PEND_TICK = 0;
    localparam int PEND_SEC  = 1;
    localparam int PEND_MIN  = 2;
    localparam int PEND_HRS  = 3;
    localparam int PEND_AL   = 4;

    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [3:0] wrap_inc4(input logic [3:0] v, input logic [3:0] max);
        return (v == max) ? 4'd0 : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timekeeper_ctrl_alarm_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alarm_fsm                                              |
// | Description : Alarm state machine with ring-duration counter.        |
// |   video_clk, reset : clock, synchronous active-high reset            |
// |   toggle           : al_toggle button pulse                          |
// |   match            : registered time equals alarm time (hh:mm)       |
// |   tick_serviced    : a 1 Hz tick is committed this cycle             |
// |   al_on, alarm     : registered armed / ringing indicators           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alarm_fsm
    import timekeeper_pkg::*;
#(
    parameter int RING_SECONDS = 60
) (
    input  logic video_clk,
    input  logic reset,
    input  logic toggle,
    input  logic match,
    input  logic tick_serviced,
    output logic al_on,
    output logic alarm
);

    localparam logic [5:0] RING_LAST = 6'(RING_SECONDS);

    alarm_state_t state_q, state_d;
    logic [5:0]   ring_q, ring_d;
    logic         al_on_q, alarm_q;

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        if (toggle) begin
            // Toggle overrides every other transition in the same cycle.
            state_d = (state_q == DISARMED) ? ARMED : DISARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (match) begin
                        state_d = RINGING;
                        ring_d  = 6'd0;
                    end
                end
                RINGING: begin
                    if (tick_serviced) begin
                        if (ring_q + 6'd1 == RING_LAST) begin
                            state_d = DONE;
                            ring_d  = 6'd0;
                        end else begin
                            ring_d = ring_q + 6'd1;
                        end
                    end
                end
                DONE: begin
                    // Wait for the matched minute to pass before re-arming.
                    if (!match) begin
                        state_d = ARMED;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            state_q <= DISARMED;
            ring_q  <= 6'd0;
            al_on_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            al_on_q <= (state_d != DISARMED);
            alarm_q <= (state_d == RINGING);
        end
    end

    assign al_on = al_on_q;
    assign alarm = alarm_q;

endmodule
`default_nettype wire

// File: rtl/timekeeper_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timekeeper_ctrl                                        |
// | Description : Time / alarm-time registers, request queue, fixed-     |
// |               priority arbiter and shared incrementer.               |
// |   video_clk, reset        : clock, synchronous active-high reset     |
// |   tick_1hz                : one-cycle pulse per second               |
// |   sec/min/hrs/al_adj      : debounced increment button pulses        |
// |   al_toggle               : arm / disarm / silence button pulse      |
// |   seconds,minutes,hours   : current time                             |
// |   al_minutes, al_hours    : alarm time                               |
// |   al_on, alarm            : armed / ringing                          |
// |   dropped                 : sticky, a request hit a pending source   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timekeeper_ctrl
    import timekeeper_pkg::*;
#(
    parameter int RING_SECONDS = 60
) (
    input  logic       video_clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       sec_adj,
    input  logic       min_adj,
    input  logic       hrs_adj,
    input  logic       al_adj,
    input  logic       al_toggle,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [3:0] hours,
    output logic [5:0] al_minutes,
    output logic [3:0] al_hours,
    output logic       al_on,
    output logic       alarm,
    output logic       dropped
);

    logic [PEND_W-1:0] pend_q, pend_d;
    logic [PEND_W-1:0] req, grant;
    logic [5:0]        seconds_q, seconds_d, minutes_q, minutes_d;
    logic [3:0]        hours_q, hours_d;
    logic [5:0]        al_minutes_q, al_minutes_d;
    logic [3:0]        al_hours_q, al_hours_d;
    logic              dropped_q, dropped_d;
    logic              match;

    always_comb begin
        req            = '0;
        req[PEND_TICK] = tick_1hz;
        req[PEND_SEC]  = sec_adj;
        req[PEND_MIN]  = min_adj;
        req[PEND_HRS]  = hrs_adj;
        req[PEND_AL]   = al_adj;

        // Isolate the lowest set pending bit (highest priority).
        grant = pend_q & (~pend_q + 5'd1);

        // A new pulse on the serviced bit re-sets it rather than being lost.
        pend_d    = (pend_q & ~grant) | req;
        dropped_d = dropped_q | (|(req & pend_q & ~grant));

        seconds_d    = seconds_q;
        minutes_d    = minutes_q;
        hours_d      = hours_q;
        al_minutes_d = al_minutes_q;
        al_hours_d   = al_hours_q;

        if (grant[PEND_TICK]) begin
            seconds_d = wrap_inc6(seconds_q, SEC_MAX);
            if (seconds_q == SEC_MAX) begin
                minutes_d = wrap_inc6(minutes_q, MIN_MAX);
                if (minutes_q == MIN_MAX) begin
                    hours_d = wrap_inc4(hours_q, HRS_MAX);
                end
            end
        end else if (grant[PEND_SEC]) begin
            seconds_d = wrap_inc6(seconds_q, SEC_MAX);
        end else if (grant[PEND_MIN]) begin
            minutes_d = wrap_inc6(minutes_q, MIN_MAX);
        end else if (grant[PEND_HRS]) begin
            hours_d = wrap_inc4(hours_q, HRS_MAX);
        end else if (grant[PEND_AL]) begin
            if (al_minutes_q == AL_MIN_MAX) begin
                al_minutes_d = 6'd0;
                al_hours_d   = wrap_inc4(al_hours_q, HRS_MAX);
            end else begin
                al_minutes_d = al_minutes_q + AL_STEP;
            end
        end
    end

    always_ff @(posedge video_clk) begin
        if (reset) begin
            pend_q       <= '0;
            dropped_q    <= 1'b0;
            seconds_q    <= 6'd0;
            minutes_q    <= 6'd0;
            hours_q      <= 4'd0;
            al_minutes_q <= 6'd0;
            al_hours_q   <= 4'd0;
        end else begin
            pend_q       <= pend_d;
            dropped_q    <= dropped_d;
            seconds_q    <= seconds_d;
            minutes_q    <= minutes_d;
            hours_q      <= hours_d;
            al_minutes_q <= al_minutes_d;
            al_hours_q   <= al_hours_d;
        end
    end

    // Seconds are ignored so the whole matched minute counts as a hit.
    assign match = (hours_q == al_hours_q) && (minutes_q == al_minutes_q);

    alarm_fsm #(
        .RING_SECONDS (RING_SECONDS)
    ) u_alarm_fsm (
        .video_clk     (video_clk),
        .reset         (reset),
        .toggle        (al_toggle),
        .match         (match),
        .tick_serviced (grant[PEND_TICK]),
        .al_on         (al_on),
        .alarm         (alarm)
    );

    assign seconds    = seconds_q;
    assign minutes    = minutes_q;
    assign hours      = hours_q;
    assign al_minutes = al_minutes_q;
    assign al_hours   = al_hours_q;
    assign dropped    = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_timekeeper_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_timekeeper_ctrl                                     |
// | Description : Self-checking bench for timekeeper_ctrl.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_timekeeper_ctrl;

    localparam int RING_SECONDS = 5;

    logic       video_clk = 1'b0;
    logic       reset;
    logic       tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle;
    logic [5:0] seconds, minutes, al_minutes;
    logic [3:0] hours, al_hours;
    logic       al_on, alarm, dropped;

    int checks = 0;
    int errors = 0;

    always #5 video_clk = ~video_clk;

    timekeeper_ctrl #(
        .RING_SECONDS (RING_SECONDS)
    ) dut (
        .video_clk  (video_clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .sec_adj    (sec_adj),
        .min_adj    (min_adj),
        .hrs_adj    (hrs_adj),
        .al_adj     (al_adj),
        .al_toggle  (al_toggle),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .al_minutes (al_minutes),
        .al_hours   (al_hours),
        .al_on      (al_on),
        .alarm      (alarm),
        .dropped    (dropped)
    );

    // req bit order: {al, hrs, min, sec, tick}
    typedef struct {
        logic [4:0] req;
        int         reps;
        int         e_sec, e_min, e_hrs, e_alm, e_alh;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge video_clk);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic tog);
        {al_adj, hrs_adj, min_adj, sec_adj, tick_1hz} = r;
        al_toggle = tog;
    endtask

    task automatic pulse(input logic [4:0] r, input logic tog);
        drive(r, tog);
        step(1);
        drive(5'b0, 1'b0);
    endtask

    // Back-to-back pulses on one source, then let the last one commit.
    task automatic run(input logic [4:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            drive(r, 1'b0);
            step(1);
        end
        drive(5'b0, 1'b0);
        step(2);
    endtask

    task automatic chk_time(input string tag, input int s, input int m, input int h);
        chk({tag, ".sec"}, int'(seconds), s);
        chk({tag, ".min"}, int'(minutes), m);
        chk({tag, ".hrs"}, int'(hours), h);
    endtask

    initial begin
        int bad;

        vecs[0]  = '{5'b00010, 59, 59,  0,  0,  0, 0};
        vecs[1]  = '{5'b00100, 59, 59, 59,  0,  0, 0};
        vecs[2]  = '{5'b00001,  1,  0,  0,  1,  0, 0};
        vecs[3]  = '{5'b01000, 10,  0,  0, 11,  0, 0};
        vecs[4]  = '{5'b00100, 59,  0, 59, 11,  0, 0};
        vecs[5]  = '{5'b00010, 59, 59, 59, 11,  0, 0};
        vecs[6]  = '{5'b00001,  1,  0,  0,  0,  0, 0};
        vecs[7]  = '{5'b10000,  6,  0,  0,  0,  0, 1};
        vecs[8]  = '{5'b10000, 66,  0,  0,  0,  0, 0};
        vecs[9]  = '{5'b01000,  3,  0,  0,  3,  0, 0};
        vecs[10] = '{5'b00100, 10,  0, 10,  3,  0, 0};
        vecs[11] = '{5'b00010, 20, 20, 10,  3,  0, 0};

        drive(5'b0, 1'b0);
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        chk_time("reset", 0, 0, 0);
        chk("reset.al_min", int'(al_minutes), 0);
        chk("reset.al_hrs", int'(al_hours), 0);
        chk("reset.al_on", int'(al_on), 0);
        chk("reset.alarm", int'(alarm), 0);
        chk("reset.dropped", int'(dropped), 0);

        for (int v = 0; v < 12; v++) begin
            run(vecs[v].req, vecs[v].reps);
            chk_time($sformatf("vec%0d", v), vecs[v].e_sec, vecs[v].e_min, vecs[v].e_hrs);
            chk($sformatf("vec%0d.al_min", v), int'(al_minutes), vecs[v].e_alm);
            chk($sformatf("vec%0d.al_hrs", v), int'(al_hours), vecs[v].e_alh);
        end
        chk("table.dropped", int'(dropped), 0);

        // Tick + sec_adj + hrs_adj together at 03:10:20.
        drive(5'b01011, 1'b0);
        step(1);
        drive(5'b0, 1'b0);
        chk("multi.k0.sec", int'(seconds), 20);
        step(1);
        chk("multi.k1.sec", int'(seconds), 21);
        chk("multi.k1.hrs", int'(hours), 3);
        step(1);
        chk("multi.k2.sec", int'(seconds), 22);
        chk("multi.k2.hrs", int'(hours), 3);
        step(1);
        chk("multi.k3.hrs", int'(hours), 4);
        chk("multi.dropped", int'(dropped), 0);

        // Second sec_adj lands while the first still waits behind a tick.
        drive(5'b00011, 1'b0);
        step(1);
        drive(5'b00010, 1'b0);
        step(1);
        drive(5'b0, 1'b0);
        step(3);
        chk("drop.dropped", int'(dropped), 1);
        chk("drop.sec", int'(seconds), 24);

        // Reset with requests pending discards them.
        drive(5'b11110, 1'b0);
        step(1);
        drive(5'b0, 1'b0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(4);
        chk_time("rstq", 0, 0, 0);
        chk("rstq.al_min", int'(al_minutes), 0);
        chk("rstq.al_hrs", int'(al_hours), 0);
        chk("rstq.dropped", int'(dropped), 0);

        // Alarm 02:30, time 02:29:59.
        run(5'b10000, 15);
        run(5'b01000, 2);
        run(5'b00100, 29);
        run(5'b00010, 59);
        chk("alset.al_min", int'(al_minutes), 30);
        chk("alset.al_hrs", int'(al_hours), 2);
        chk_time("alset", 59, 29, 2);
        pulse(5'b0, 1'b1);
        chk("arm.al_on", int'(al_on), 1);
        chk("arm.alarm", int'(alarm), 0);

        pulse(5'b00001, 1'b0);
        step(1);
        chk_time("ring.k1", 0, 30, 2);
        chk("ring.k1.alarm", int'(alarm), 0);
        step(1);
        chk("ring.k2.alarm", int'(alarm), 1);

        for (int i = 0; i < RING_SECONDS; i++) begin
            pulse(5'b00001, 1'b0);
            step(2);
            if (i == RING_SECONDS - 2) chk("ring.hold", int'(alarm), 1);
        end
        chk("ring.done.alarm", int'(alarm), 0);
        chk("ring.done.al_on", int'(al_on), 1);
        chk("ring.done.sec", int'(seconds), RING_SECONDS);

        bad = 0;
        for (int i = RING_SECONDS; i < 59; i++) begin
            pulse(5'b00001, 1'b0);
            step(2);
            if (alarm) bad++;
        end
        chk("noreing.count", bad, 0);
        pulse(5'b00001, 1'b0);
        step(3);
        chk_time("rearm", 0, 31, 2);
        chk("rearm.alarm", int'(alarm), 0);

        // Adjust minutes back into 02:30 while re-armed: must ring.
        run(5'b00100, 59);
        chk("adjring.min", int'(minutes), 30);
        chk("adjring.alarm", int'(alarm), 1);
        pulse(5'b0, 1'b1);
        chk("silence.alarm", int'(alarm), 0);
        chk("silence.al_on", int'(al_on), 0);

        // Toggle on the same cycle the match first appears while armed.
        run(5'b00100, 1);
        pulse(5'b0, 1'b1);
        chk("rearm2.al_on", int'(al_on), 1);
        for (int i = 0; i < 59; i++) begin
            drive(5'b00100, 1'b0);
            step(1);
        end
        drive(5'b0, 1'b0);
        step(1);
        chk("tmatch.min", int'(minutes), 30);
        pulse(5'b0, 1'b1);
        chk("tmatch.al_on", int'(al_on), 0);
        chk("tmatch.alarm", int'(alarm), 0);
        step(3);
        chk("tmatch.later.alarm", int'(alarm), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
